// File: rtl/rcv_ctrl_pkg.sv
// rcv_ctrl_pkg: shared defaults and FSM state type
// for the UART receive-side controller.
package rcv_ctrl_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_CLR
  } rx_state_t;

endpackage

// File: rtl/rcv_fifo_buf.sv
// rcv_fifo_buf: first-word-fall-through byte FIFO
// with occupancy count; DEPTH must be a power of 2.
module rcv_fifo_buf
  import rcv_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // occupancy; push+pop together holds
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcv_rx_ctrl.sv
// rcv_rx_ctrl: drains receiver bytes into a FIFO,
// tracks sticky errors, raises irq. Option: RCV_IRQ_THRESH_EN.
module rcv_rx_ctrl
  import rcv_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              data_ready,
  input  logic              overrun_error,
  input  logic              framing_error,
  output logic              data_read,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  input  logic              clear_err,
  output logic              err_framing,
  output logic              err_overrun,
  output logic              err_stall,
`ifdef RCV_IRQ_THRESH_EN
  input  logic [CNT_W-1:0]  irq_thresh,
`endif
  output logic              irq
);

  rx_state_t state;
  rx_state_t state_n;
  logic      push;
  logic      stall;
  logic      fe_q;
  logic      data_term;

  rcv_fifo_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .wdata   (rx_data),
    .pop     (pop),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign data_read = (state == ACK);

`ifdef RCV_IRQ_THRESH_EN
  assign data_term = (irq_thresh != '0) &&
                     (count >= irq_thresh);
`else
  assign data_term = !empty;
`endif

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // next state, capture and stall detect
  always_comb begin
    state_n = state;
    push    = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_ready && !full) begin
          push    = 1'b1;
          state_n = ACK;
        end else if (data_ready) begin
          stall = 1'b1;
        end
      end
      ACK:      state_n = WAIT_CLR;
      WAIT_CLR: if (!data_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // sticky errors; a set beats a clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fe_q        <= 1'b0;
      err_framing <= 1'b0;
      err_overrun <= 1'b0;
      err_stall   <= 1'b0;
    end else begin
      fe_q <= framing_error;
      if (framing_error && !fe_q) err_framing <= 1'b1;
      else if (clear_err)         err_framing <= 1'b0;
      if (overrun_error)          err_overrun <= 1'b1;
      else if (clear_err)         err_overrun <= 1'b0;
      if (stall)                  err_stall   <= 1'b1;
      else if (clear_err)         err_stall   <= 1'b0;
    end
  end

  // registered interrupt request
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) irq <= 1'b0;
    else        irq <= data_term || err_framing ||
                       err_overrun || err_stall;
  end

endmodule

// File: tb/tb_rcv_rx_ctrl.sv
// tb_rcv_rx_ctrl: directed vectors for rcv_rx_ctrl
// with hand-computed expected values.
`timescale 1ns/1ps
module tb_rcv_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int CW    = 4;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic [DW-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;
  logic          data_read;
  logic          pop;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          clear_err;
  logic          err_framing;
  logic          err_overrun;
  logic          err_stall;
  logic          irq;
`ifdef RCV_IRQ_THRESH_EN
  logic [CW-1:0] irq_thresh;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q [$];

  always #5 tb_clk = ~tb_clk;

  rcv_rx_ctrl #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .data_read     (data_read),
    .pop           (pop),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .clear_err     (clear_err),
    .err_framing   (err_framing),
    .err_overrun   (err_overrun),
    .err_stall     (err_stall),
`ifdef RCV_IRQ_THRESH_EN
    .irq_thresh    (irq_thresh),
`endif
    .irq           (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // full receiver handshake, bounded wait
  task automatic send(input logic [7:0] b);
    bit seen = 0;
    rx_data    = b;
    data_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (data_read) seen = 1;
    end
    if (!seen) chk("send_timeout", 0, 1);
    data_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_chk(input string tag,
                         input logic [7:0] exp);
    chk(tag, rd_data, exp);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    n_rst         = 1'b0;
    rx_data       = '0;
    data_ready    = 1'b0;
    overrun_error = 1'b0;
    framing_error = 1'b0;
    pop           = 1'b0;
    clear_err     = 1'b0;
`ifdef RCV_IRQ_THRESH_EN
    irq_thresh    = 4'd1;
`endif
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_irq",   irq, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_dread", data_read, 0);

    // single byte
    rx_data    = 8'hF0;
    data_ready = 1'b1;
    tick();
    chk("sb_dread", data_read, 1);
    chk("sb_count", count, 1);
    chk("sb_rdata", rd_data, 8'hF0);
    tick();
    chk("sb_dread_off", data_read, 0);
    chk("sb_irq", irq, 1);
    data_ready = 1'b0;
    tick();
    tick();
    chk("sb_nodouble", count, 1);
    pop_chk("sb_pop", 8'hF0);
    chk("sb_empty", empty, 1);
    tick();
    chk("sb_irq_off", irq, 0);
    pop_chk("pop_on_empty", 8'h00);
    chk("pop_empty_cnt", count, 0);

    // reset during WAIT_CLR, byte re-captured
    rx_data    = 8'h5A;
    data_ready = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_dread", data_read, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_irq",   irq, 0);
    chk("mid_rst_rdata", rd_data, 0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("recap_count", count, 1);
    chk("recap_dread", data_read, 1);
    data_ready = 1'b0;
    tick();
    tick();
    pop_chk("recap_pop", 8'h5A);

    // fill and stall
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    rx_data    = 8'h09;
    data_ready = 1'b1;
    tick();
    chk("stall_dread", data_read, 0);
    tick();
    tick();
    chk("stall_dread2", data_read, 0);
    chk("stall_err", err_stall, 1);
    chk("stall_count", count, 8);
    pop_chk("stall_pop1", 8'h01);
    chk("stall_nopush", count, 7);
    chk("stall_nodread", data_read, 0);
    tick();
    chk("stall_cap", data_read, 1);
    chk("stall_cnt8", count, 8);
    data_ready = 1'b0;
    tick();
    tick();
    for (int i = 2; i <= 9; i++)
      pop_chk("stall_order", 8'(i));
    chk("stall_empty", empty, 1);

    // wrap with simultaneous push+pop
    q.delete();
    for (int i = 0; i < 3; i++) begin
      send(8'(i));
      q.push_back(8'(i));
    end
    chk("wrap_cnt3", count, 3);
    for (int i = 3; i < 20; i++) begin
      rx_data    = 8'(i);
      data_ready = 1'b1;
      chk("wrap_head", rd_data, q.pop_front());
      q.push_back(8'(i));
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("wrap_dread", data_read, 1);
      chk("wrap_hold", count, 3);
      data_ready = 1'b0;
      tick();
      tick();
    end
    while (q.size() > 0)
      pop_chk("wrap_tail", q.pop_front());
    chk("wrap_empty", empty, 1);

    // errors
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_stall", err_stall, 0);
    framing_error = 1'b1;
    tick();
    framing_error = 1'b0;
    chk("fe_set", err_framing, 1);
    chk("fe_nowrite", count, 0);
    tick();
    chk("fe_irq", irq, 1);
    overrun_error = 1'b1;
    tick();
    overrun_error = 1'b0;
    chk("ov_set", err_overrun, 1);
    tick();
    chk("ov_sticky", err_overrun, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_fe", err_framing, 0);
    chk("clr_ov", err_overrun, 0);
    tick();
    tick();
    chk("clr_irq", irq, 0);
    framing_error = 1'b1;
    clear_err     = 1'b1;
    tick();
    framing_error = 1'b0;
    clear_err     = 1'b0;
    chk("set_wins", err_framing, 1);
    chk("set_wins_ov", err_overrun, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

`ifdef RCV_IRQ_THRESH_EN
    irq_thresh = 4'd4;
    for (int i = 0; i < 3; i++) send(8'(i));
    tick();
    chk("th_cnt3", irq, 0);
    send(8'h03);
    chk("th_cnt4", irq, 1);
    irq_thresh = 4'd0;
    for (int i = 4; i < 8; i++) send(8'(i));
    tick();
    chk("th_zero_full", full, 1);
    chk("th_zero_irq", irq, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
